// File: rtl/vregfile.sv
// Vector register file: DEPTH x (LANES*ELEM_W) storage, two bypassed read ports,
// one lane-masked write port, per-register busy scoreboard and a post-reset clear sweep.
module vregfile #(
  parameter  int LANES    = 4,
  parameter  int ELEM_W   = 32,
  parameter  int DEPTH    = 16,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH),
  localparam int DW       = LANES * ELEM_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_busy,
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     ra2,
  output logic [DW-1:0]     rd1,
  output logic [DW-1:0]     rd2,
  output logic              busy1,
  output logic              busy2,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [LANES-1:0]  wmask,
  input  logic [DW-1:0]     wd,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_wa,
  output logic              iss_stall
);

  localparam logic ZR = (ZERO_REG != 0);

  logic [DW-1:0]    r_mem [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic [AW-1:0]    r_cnt;
  logic             r_init;

  logic             w_we;
  logic             w_wr_ok;
  logic             w_fwd1;
  logic             w_fwd2;
  logic             w_fwdi;
  logic             w_iss_ok;
  logic             w_zero1;
  logic             w_zero2;
  logic [DEPTH-1:0] w_busy_nxt;

  assign init_busy = r_init;

  // Traffic is ignored entirely while the clear sweep is running.
  assign w_we    = we & ~r_init;
  assign w_wr_ok = w_we & ~(ZR & (wa == '0));

  assign w_fwd1  = w_we & (wa == ra1);
  assign w_fwd2  = w_we & (wa == ra2);
  assign w_fwdi  = w_we & (wa == iss_wa);

  assign busy1     = ~r_init & r_busy[ra1] & ~w_fwd1;
  assign busy2     = ~r_init & r_busy[ra2] & ~w_fwd2;
  assign iss_stall = r_init | (iss_valid & r_busy[iss_wa] & ~w_fwdi);
  // Issue to the zero register is accepted but never marks it busy.
  assign w_iss_ok  = iss_valid & ~iss_stall & ~(ZR & (iss_wa == '0));

  assign w_zero1 = r_init | (ZR & (ra1 == '0));
  assign w_zero2 = r_init | (ZR & (ra2 == '0));

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int l = 0; l < LANES; l++) begin
      if (!w_zero1) begin
        rd1[l*ELEM_W +: ELEM_W] = (w_fwd1 & wmask[l]) ? wd[l*ELEM_W +: ELEM_W]
                                                       : r_mem[ra1][l*ELEM_W +: ELEM_W];
      end
      if (!w_zero2) begin
        rd2[l*ELEM_W +: ELEM_W] = (w_fwd2 & wmask[l]) ? wd[l*ELEM_W +: ELEM_W]
                                                       : r_mem[ra2][l*ELEM_W +: ELEM_W];
      end
    end
  end

  // Set is applied after clear so a same-cycle reservation wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_we)     w_busy_nxt[wa]     = 1'b0;
    if (w_iss_ok) w_busy_nxt[iss_wa] = 1'b1;
    if (ZR)       w_busy_nxt[0]      = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_init <= 1'b1;
      r_cnt  <= '0;
      r_busy <= '0;
    end else if (r_init) begin
      if (r_cnt == AW'(DEPTH - 1)) r_init <= 1'b0;
      else                         r_cnt  <= r_cnt + 1'b1;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Storage has no reset of its own; the sweep zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (r_init) begin
        r_mem[r_cnt] <= '0;
      end else if (w_wr_ok) begin
        for (int l = 0; l < LANES; l++) begin
          if (wmask[l]) r_mem[wa][l*ELEM_W +: ELEM_W] <= wd[l*ELEM_W +: ELEM_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_vregfile.sv
// Bench for vregfile: directed scenarios plus randomized traffic checked against
// a lane/array reference model of the register file and scoreboard.
module tb_vregfile;

  localparam int LANES  = 4;
  localparam int ELEM_W = 32;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int DW     = LANES * ELEM_W;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             init_busy;
  logic [AW-1:0]    ra1 = '0, ra2 = '0;
  logic [DW-1:0]    rd1, rd2;
  logic             busy1, busy2;
  logic             we = 1'b0;
  logic [AW-1:0]    wa = '0;
  logic [LANES-1:0] wmask = '0;
  logic [DW-1:0]    wd = '0;
  logic             iss_valid = 1'b0;
  logic [AW-1:0]    iss_wa = '0;
  logic             iss_stall;

  int checks = 0;
  int errors = 0;

  // Reference model: registers as lane arrays, busy flags, sweep edges remaining.
  logic [ELEM_W-1:0] m_mem [DEPTH][LANES];
  bit                m_busy [DEPTH];
  int                m_init_left = DEPTH;

  always #5 clk = ~clk;

  vregfile #(.LANES(LANES), .ELEM_W(ELEM_W), .DEPTH(DEPTH), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .init_busy(init_busy),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .busy1(busy1), .busy2(busy2),
    .we(we), .wa(wa), .wmask(wmask), .wd(wd),
    .iss_valid(iss_valid), .iss_wa(iss_wa), .iss_stall(iss_stall)
  );

  function automatic bit m_we_eff();
    return we && (m_init_left == 0);
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] ra);
    logic [DW-1:0] v;
    v = '0;
    if (m_init_left > 0 || ra == 0) return v;
    for (int l = 0; l < LANES; l++) begin
      if (m_we_eff() && wa == ra && wmask[l]) v[l*ELEM_W +: ELEM_W] = wd[l*ELEM_W +: ELEM_W];
      else                                    v[l*ELEM_W +: ELEM_W] = m_mem[ra][l];
    end
    return v;
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] ra);
    if (m_init_left > 0) return 1'b0;
    return m_busy[ra] && !(m_we_eff() && wa == ra);
  endfunction

  function automatic logic exp_stall();
    if (m_init_left > 0) return 1'b1;
    return iss_valid && m_busy[iss_wa] && !(m_we_eff() && wa == iss_wa);
  endfunction

  task automatic tick();
    logic             c_rst, c_we, c_iv, c_stall;
    logic [AW-1:0]    c_wa, c_iwa;
    logic [LANES-1:0] c_mask;
    logic [DW-1:0]    c_wd;
    c_rst = rst; c_we = we; c_iv = iss_valid; c_wa = wa; c_iwa = iss_wa;
    c_mask = wmask; c_wd = wd; c_stall = exp_stall();
    @(posedge clk);
    if (!c_rst) begin
      for (int r = 0; r < DEPTH; r++) m_busy[r] = 1'b0;
      m_init_left = DEPTH;
    end else if (m_init_left > 0) begin
      for (int l = 0; l < LANES; l++) m_mem[DEPTH - m_init_left][l] = '0;
      m_init_left--;
    end else begin
      if (c_we) begin
        if (c_wa != 0)
          for (int l = 0; l < LANES; l++)
            if (c_mask[l]) m_mem[c_wa][l] = c_wd[l*ELEM_W +: ELEM_W];
        m_busy[c_wa] = 1'b0;
      end
      if (c_iv && !c_stall && c_iwa != 0) m_busy[c_iwa] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    we = 1'b0; iss_valid = 1'b0; wmask = '0; wd = '0;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b0; idle();
    we = 1'b1; wa = 4'd4; wmask = '1; wd = {4{32'h5A5A5A5A}}; ra1 = 4'd4; ra2 = 4'd6;
    repeat (3) tick();
    #1;
    checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL reset_init_busy: got %b expected 1", init_busy); end
    checks++; if (iss_stall !== 1'b1) begin errors++; $display("FAIL reset_iss_stall: got %b expected 1", iss_stall); end
    checks++; if (rd1 !== '0 || rd2 !== '0) begin errors++; $display("FAIL reset_rd: got %h / %h expected 0", rd1, rd2); end
    checks++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b%b expected 00", busy1, busy2); end
    rst = 1'b1; iss_valid = 1'b1; iss_wa = 4'd6;
    n = 0;
    while (init_busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    checks++; if (n != DEPTH) begin errors++; $display("FAIL sweep_len: got %0d edges expected %0d", n, DEPTH); end
    idle();
    for (int r = 0; r < DEPTH; r++) begin
      ra1 = AW'(r); ra2 = AW'(r);
      #1;
      checks++;
      if (rd1 !== '0 || busy2 !== 1'b0) begin
        errors++; $display("FAIL sweep_clear r%0d: got rd=%h busy=%b expected 0/0", r, rd1, busy2);
      end
    end
  endtask

  task automatic test_masked_write();
    logic [DW-1:0] req;
    req = {32'h0, 32'hCCCC, 32'h0, 32'hAAAA};
    we = 1'b1; wa = 4'd5; wmask = 4'b0101; wd = {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA}; ra1 = 4'd5;
    #1;
    checks++; if (rd1 !== req) begin errors++; $display("FAIL mask_bypass: got %h expected %h", rd1, req); end
    tick();
    idle();
    #1;
    checks++; if (rd1 !== req) begin errors++; $display("FAIL mask_stored: got %h expected %h", rd1, req); end
  endtask

  task automatic test_zero_reg();
    we = 1'b1; wa = 4'd0; wmask = '1; wd = {4{32'hFFFFFFFF}}; ra1 = 4'd0;
    #1;
    checks++; if (rd1 !== '0) begin errors++; $display("FAIL zero_bypass: got %h expected 0", rd1); end
    tick();
    idle();
    #1;
    checks++; if (rd1 !== '0) begin errors++; $display("FAIL zero_stored: got %h expected 0", rd1); end
    iss_valid = 1'b1; iss_wa = 4'd0;
    #1;
    checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL zero_issue_stall: got %b expected 0", iss_stall); end
    tick();
    idle();
    #1;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b expected 0", busy1); end
  endtask

  task automatic test_hazard();
    iss_valid = 1'b1; iss_wa = 4'd3; ra1 = 4'd3;
    #1;
    checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL haz_first_issue: got %b expected 0", iss_stall); end
    tick();
    idle();
    #1;
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL haz_busy_set: got %b expected 1", busy1); end
    iss_valid = 1'b1; iss_wa = 4'd3;
    #1;
    checks++; if (iss_stall !== 1'b1) begin errors++; $display("FAIL haz_reissue_stall: got %b expected 1", iss_stall); end
    tick();
    idle();
    we = 1'b1; wa = 4'd3; wmask = 4'b0000;
    #1;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL haz_fwd_clear: got %b expected 0", busy1); end
    tick();
    idle();
    #1;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL haz_cleared: got %b expected 0", busy1); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    iss_valid = 1'b1; iss_wa = 4'd7;
    tick();
    we = 1'b1; wa = 4'd7; wmask = '1; wd = v; iss_valid = 1'b1; iss_wa = 4'd7; ra1 = 4'd7;
    #1;
    checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL b2b_stall: got %b expected 0", iss_stall); end
    tick();
    idle();
    #1;
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", busy1); end
    checks++; if (rd1 !== v) begin errors++; $display("FAIL b2b_data: got %h expected %h", rd1, v); end
  endtask

  task automatic test_reset_mid();
    int n;
    iss_valid = 1'b1; iss_wa = 4'd2;
    we = 1'b1; wa = 4'd4; wmask = '1; wd = {4{32'h1234}};
    tick();
    idle();
    ra1 = 4'd4; ra2 = 4'd2;
    #1;
    checks++; if (rd1 !== {4{32'h1234}} || busy2 !== 1'b1) begin
      errors++; $display("FAIL mid_pre: got rd=%h busy=%b expected %h/1", rd1, busy2, {4{32'h1234}});
    end
    rst = 1'b0; we = 1'b1; wa = 4'd9; wmask = '1; wd = {4{32'hBEEF}}; iss_valid = 1'b1; iss_wa = 4'd10;
    tick();
    rst = 1'b1; idle();
    #1;
    checks++; if (init_busy !== 1'b1 || busy2 !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got init=%b busy=%b expected 1/0", init_busy, busy2);
    end
    n = 0;
    while (init_busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    checks++; if (n != DEPTH) begin errors++; $display("FAIL mid_sweep_len: got %0d expected %0d", n, DEPTH); end
    ra1 = 4'd4; ra2 = 4'd2;
    #1;
    checks++; if (rd1 !== '0 || busy2 !== 1'b0) begin
      errors++; $display("FAIL mid_after: got rd=%h busy=%b expected 0/0", rd1, busy2);
    end
    ra1 = 4'd9; ra2 = 4'd10;
    #1;
    checks++; if (rd1 !== '0 || busy2 !== 1'b0) begin
      errors++; $display("FAIL mid_inflight: got rd=%h busy=%b expected 0/0", rd1, busy2);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 199) != 0);
      we        = $urandom_range(0, 1);
      wa        = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 5));
      wmask     = LANES'($urandom);
      wd        = {$urandom, $urandom, $urandom, $urandom};
      iss_valid = $urandom_range(0, 1);
      iss_wa    = AW'($urandom_range(0, 5));
      ra1       = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 5));
      ra2       = AW'($urandom);
      #1;
      checks++;
      if (rd1 !== exp_rd(ra1) || rd2 !== exp_rd(ra2)) begin
        errors++; $display("FAIL rnd_rd cyc%0d: got %h/%h expected %h/%h", i, rd1, rd2, exp_rd(ra1), exp_rd(ra2));
      end
      checks++;
      if (busy1 !== exp_busy(ra1) || busy2 !== exp_busy(ra2)) begin
        errors++; $display("FAIL rnd_busy cyc%0d: got %b%b expected %b%b", i, busy1, busy2, exp_busy(ra1), exp_busy(ra2));
      end
      checks++;
      if (iss_stall !== exp_stall() || init_busy !== (m_init_left > 0)) begin
        errors++; $display("FAIL rnd_ctl cyc%0d: got stall=%b init=%b expected %b/%b", i, iss_stall, init_busy, exp_stall(), m_init_left > 0);
      end
      tick();
    end
    rst = 1'b1; idle();
  endtask

  initial begin
    test_reset();
    test_masked_write();
    test_zero_reg();
    test_hazard();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vregfile.md
# vregfile

Parametrised vector register file for the vector datapath: DEPTH registers of LANES × ELEM_W bits, two combinational read ports with write-through bypass, one lane-masked write port, and a per-register busy scoreboard for the issue stage. After reset it runs a self-clearing sweep, one register per cycle, before accepting traffic. It replaces the scalar 32×32 file in vector-capable configurations; LANES=1, ELEM_W=32, DEPTH=32 gives scalar-equivalent storage.

## Interface
- LANES, 4, element lanes per register
- ELEM_W, 32, bits per lane
- DEPTH, 16, number of registers (power of two, ≥2); AW = $clog2(DEPTH)
- ZERO_REG, 1, when 1, register 0 is hard-wired zero: never written, never busy
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- init_busy  out  1  high while the clear sweep runs
- ra1, ra2  in  AW  read addresses
- rd1, rd2  out  LANES*ELEM_W  read data; lane i = bits [i*ELEM_W +: ELEM_W]
- busy1, busy2  out  1  scoreboard state of ra1/ra2
- we  in  1  write enable
- wa  in  AW  write address
- wmask  in  LANES  per-lane write mask
- wd  in  LANES*ELEM_W  write data
- iss_valid  in  1  issue request reserving destination iss_wa
- iss_wa  in  AW  destination to reserve
- iss_stall  out  1  reservation refused this cycle

## Operation
- Clear sweep: while rst=0, sweep counter = 0, init_busy = 1, all busy bits = 0. After release, each cycle writes zero to register[counter] and increments it; after register DEPTH-1 is cleared, init_busy drops. While init_busy: we and iss_valid ignored, rd1/rd2 = 0, busy1/busy2 = 0, iss_stall = 1.
- Write: when we and not init_busy, lanes with wmask[i]=1 of register[wa] take wd lane i; other lanes hold. Writes to register 0 are dropped when ZERO_REG=1.
- Read: rd = register[ra], with per-lane bypass. If we and wa==ra and wmask[i], lane i shows wd lane i in the same cycle. Register 0 reads all zero when ZERO_REG=1, including under bypass.
- Scoreboard: busy[DEPTH], one bit per register.
  - Any accepted write clears busy[wa], even when wmask = 0.
  - fwd_clr(a) = we & wa==a.
  - busyN = busy[raN] & ~fwd_clr(raN).
  - iss_stall = init_busy | (iss_valid & busy[iss_wa] & ~fwd_clr(iss_wa)).
  - If iss_valid and not iss_stall: busy[iss_wa] is set on the next edge. Set wins over a same-cycle clear of the same address.
  - With ZERO_REG=1, issue to register 0 is accepted and busy[0] stays 0.
- Reset mid-operation (rst low for ≥1 edge): busy bits clear and the sweep restarts from register 0. In-flight write/issue on that edge is discarded.

## Timing
- Reads, bypass, busy1/2, iss_stall: combinational, 0-cycle.
- Write and scoreboard updates: visible in state 1 cycle after the edge.
- Reset values: init_busy=1; rd1/rd2=0; busy1/busy2=0; iss_stall=1.
- Sweep length: release on edge E0 → init_busy low after edge E0+DEPTH, so the first write is accepted on edge E0+DEPTH+1. With ZERO_REG=1, register 0 is still swept; there is no shortcut.
- Sweep counter wraps never: it saturates once done and only restarts on reset.

## Test plan
- Reset/sweep, DEPTH=16: hold rst=0 for 3 cycles, release → init_busy high for exactly 16 edges, then low. Every register reads 0x0 across all lanes. Issue and write attempted during the sweep have no effect.
- Masked write + bypass: write reg 5, wd lanes = {0xDDDD,0xCCCC,0xBBBB,0xAAAA}, wmask=0101 with ra1=5 in the same cycle → rd1 lanes {0,0xCCCC,0,0xAAAA} combinationally. Same value holds next cycle with we=0.
- Zero register: we=1, wa=0, wd=all 0xFFFFFFFF, ra1=0 → rd1=0 in the same and the next cycle. Issue to reg 0 → iss_stall=0 and busy1 stays 0.
- Scoreboard hazard: issue reg 3 → next cycle busy1=1 with ra1=3. Re-issue reg 3 → iss_stall=1. Write reg 3 → busy1=0 in the same cycle, busy bit clear after the edge.
- Simultaneous clear/set: reg 7 busy; same cycle we=1, wa=7 and iss_valid=1, iss_wa=7 → iss_stall=0, data written, busy[7]=1 after the edge.
- Reset mid-operation: reg 2 busy and reg 4 = 0x1234 lanes; assert rst=0 for 1 cycle → busy all 0, init_busy=1, full 16-cycle sweep reruns, reg 4 reads 0 after.
